random_delay_gen: RTL and testbench
===================================

Name: random_delay_gen

Overview:
- Stimulus-side counterpart of the reaction-time counter: on a start request it waits a pseudo-random interval, then asserts random_finish, which the counter uses as its go signal.
- Detects a false start, i.e. react asserted before the stimulus fires.
- Sits between the top-level control/button logic and the reaction-time counter; owns the only random source in the detector.

Parameters:
- MIN_DELAY, 1000, fixed minimum wait in ticks (1 tick = 1 ms at the system tick rate).
- DELAY_RANGE_BITS, 12, number of LFSR bits added to MIN_DELAY; random part is 0..2^DELAY_RANGE_BITS-1.
- TICK_DIV, 1, clock cycles per tick (prescaler); 1 = one tick per clock.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high; sampled on clock rising edge; overrides everything.
- start  input  1  round request; only its rising edge is acted on.
- react  input  1  player button, level (already debounced upstream).
- random_finish  output  1  stimulus-active flag to the reaction-time counter; registered.
- false_start  output  1  react seen during the wait; registered, sticky until the next round.
- busy  output  1  high while in WAIT.
- delay_ms  output  16  delay chosen for the current round, in ticks; held until the next round.

Behaviour:
- Reset (sync, active-high) values:
  - random_finish=0, false_start=0, busy=0, delay_ms=0
  - state=IDLE, LFSR=SEED, prescaler=0, delay counter=0, start edge register=0
- Reset mid-round aborts immediately with no residual outputs.
- LFSR:
  - 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Advances every clock regardless of state; never reaches 0.
- Start edge: start_rise = start & ~start_q; start_q is registered every clock.
- Delay value:
  - D = MIN_DELAY + LFSR[DELAY_RANGE_BITS-1:0], sampled in the start_rise cycle.
  - Elaboration constraint: MIN_DELAY + 2^DELAY_RANGE_BITS - 1 < 65536 and MIN_DELAY >= 1.
- FSM states: IDLE, WAIT, FIRE, FALSE.
- IDLE: on start_rise, load counter=D and delay_ms=D, clear prescaler, go to WAIT (busy=1 next cycle).
- WAIT:
  - Prescaler counts 0..TICK_DIV-1; the tick fires when the prescaler is at TICK_DIV-1.
  - The counter decrements on each tick.
  - When a tick occurs with counter==1: go to FIRE, random_finish=1 on the same edge.
  - Latency: random_finish first sampled high exactly D*TICK_DIV clock edges after the edge that sampled start_rise.
  - react==1 (level) in any WAIT cycle: go to FALSE, false_start=1, random_finish stays 0. React takes priority over a same-cycle final tick.
  - start_rise in WAIT is ignored; delay_ms is unchanged.
- FIRE: random_finish held at 1; react is ignored here, since the counter consumes it.
- FALSE: false_start held at 1.
- FIRE or FALSE on start_rise:
  - Immediately begin a new round: load a new D, go to WAIT.
  - random_finish and false_start clear on that same edge.
  - The counter therefore sees random_finish fall and clears itself.
- busy = (state==WAIT), registered alongside the state.
- Simultaneous reset and start: reset wins; no round starts.

Decomposition:
- Shared package `reaction_pkg`: FSM state enum (IDLE, WAIT, FIRE, FALSE), LFSR_MASK = 16'hB400, default SEED.
- One natural sub-module, `lfsr16`: clock, reset, seed parameter, 16-bit state output, free-running.
- FSM, prescaler and delay counter stay in `random_delay_gen`.

Test Plan:
- Reset then idle 100 cycles with start=0 -> random_finish=0, false_start=0, busy=0, delay_ms=0 throughout; LFSR is never 0.
- Directed timing, MIN_DELAY=5, DELAY_RANGE_BITS=2, TICK_DIV=1; pulse start -> delay_ms in 5..8, random_finish rises exactly delay_ms edges after the start_rise edge and stays high.
- Prescaler, TICK_DIV=4, same delays -> rise after exactly 4*delay_ms edges; busy high for exactly that many cycles.
- False start: react=1 three cycles into WAIT -> false_start=1 next edge, random_finish stays 0 for 20000 cycles; a new start edge clears false_start and reloads.
- Edge cases:
  - Second start edge during WAIT -> ignored, delay_ms and timing unchanged.
  - Start held high for 50 cycles -> exactly one round.
  - react and the final tick in the same cycle -> FALSE, not FIRE.
- Reset asserted mid-WAIT and in FIRE -> all outputs 0 next edge; after release and a restart, the delay sequence replays identically from SEED (same delay_ms as the first run, given the same cycle offset of start).

Source files
------------

// File: rtl/reaction_pkg.sv
// ============================================================================
// reaction_pkg : shared types and constants for the reaction-time detector.
// Rev 1.0
// ============================================================================
`default_nettype none

package reaction_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FIRE  = 2'd2,
    S_FALSE = 2'd3
  } state_t;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/random_delay_gen_lfsr16.sv
// ============================================================================
// lfsr16 : free-running 16-bit Galois LFSR, reloads SEED on reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // A nonzero seed keeps the sequence off the all-zero lockup state.
  always_comb begin
    state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/random_delay_gen.sv
// ============================================================================
// random_delay_gen : waits a pseudo-random number of ticks after a start edge,
// then raises random_finish; flags react seen during the wait. Rev 1.0
// ============================================================================
`default_nettype none

module random_delay_gen
  import reaction_pkg::*;
#(
  parameter int          MIN_DELAY        = 1000,
  parameter int          DELAY_RANGE_BITS = 12,
  parameter int          TICK_DIV         = 1,
  parameter logic [15:0] SEED             = DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        react,
  output logic        random_finish,
  output logic        false_start,
  output logic        busy,
  output logic [15:0] delay_ms
);

  localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] RANGE_MASK = 16'((32'd1 << DELAY_RANGE_BITS) - 32'd1);

  logic [15:0]   lfsr;
  state_t        state_q,  state_d;
  logic          start_q,  start_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [15:0]   cnt_q,    cnt_d;
  logic [15:0]   delay_q,  delay_d;
  logic          finish_q, finish_d;
  logic          fstart_q, fstart_d;
  logic          busy_q,   busy_d;

  logic          start_rise;
  logic          tick;
  logic [15:0]   new_delay;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr)
  );

  assign start_rise = start & ~start_q;
  assign tick       = (presc_q == PRESC_LAST);
  assign new_delay  = 16'(MIN_DELAY) + (lfsr & RANGE_MASK);

  always_comb begin
    state_d  = state_q;
    start_d  = start;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    finish_d = finish_q;
    fstart_d = fstart_q;

    case (state_q)
      S_IDLE, S_FIRE, S_FALSE: begin
        // A new round clears both result flags on the same edge it starts.
        if (start_rise) begin
          state_d  = S_WAIT;
          cnt_d    = new_delay;
          delay_d  = new_delay;
          presc_d  = '0;
          finish_d = 1'b0;
          fstart_d = 1'b0;
        end
      end
      S_WAIT: begin
        // React outranks a final tick landing in the same cycle.
        if (react) begin
          state_d  = S_FALSE;
          fstart_d = 1'b1;
        end else if (tick) begin
          presc_d = '0;
          if (cnt_q == 16'd1) begin
            state_d  = S_FIRE;
            finish_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= 16'd0;
      delay_q  <= 16'd0;
      finish_q <= 1'b0;
      fstart_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      finish_q <= finish_d;
      fstart_q <= fstart_d;
      busy_q   <= busy_d;
    end
  end

  assign random_finish = finish_q;
  assign false_start   = fstart_q;
  assign busy          = busy_q;
  assign delay_ms      = delay_q;

endmodule

`default_nettype wire

// File: tb/tb_random_delay_gen.sv
// ============================================================================
// tb_random_delay_gen : bench for random_delay_gen with TICK_DIV=1 and =4 copies.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_random_delay_gen;

  localparam int MIN_D = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        start0, react0, rf0, fs0, busy0;
  logic        start1, react1, rf1, fs1, busy1;
  logic [15:0] dly0, dly1;

  random_delay_gen #(.MIN_DELAY(5), .DELAY_RANGE_BITS(2), .TICK_DIV(1), .SEED(16'hACE1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .react(react0),
    .random_finish(rf0), .false_start(fs0), .busy(busy0), .delay_ms(dly0));

  random_delay_gen #(.MIN_DELAY(5), .DELAY_RANGE_BITS(2), .TICK_DIV(4), .SEED(16'hACE1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .react(react1),
    .random_finish(rf1), .false_start(fs1), .busy(busy1), .delay_ms(dly1));

  // Reference random source: the polynomial's sequence from SEED, one step per clock.
  logic [15:0] m_lfsr;
  always @(posedge clock) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int k;          // 0: TICK_DIV=1 copy, 1: TICK_DIV=4 copy
    int react_at;   // >=0 cycle index, -1 none, -2 on final tick, -3 first FIRE cycle
    bit extra;      // second start edge during the wait
    int hold;       // cycles start stays high
    int tail;       // cycles observed after the outcome
    bit exp_false;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [18:0] outs(input int k);
    return (k == 1) ? {rf1, fs1, busy1, dly1} : {rf0, fs0, busy0, dly0};
  endfunction

  task automatic drive(input int k, input logic s, input logic r);
    if (k == 1) begin start1 = s; react1 = r; end
    else        begin start0 = s; react0 = r; end
  endtask

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got rf=%0b fs=%0b busy=%0b dly=%0d, expected rf=%0b fs=%0b busy=%0b dly=%0d",
               name, $time, got[18], got[17], got[16], got[15:0], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic reset_and_idle(input int idle);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    step();
    step();
    check("reset_dut0", outs(0), 19'd0);
    check("reset_dut1", outs(1), 19'd0);
    reset = 1'b0;
    for (int i = 0; i < idle; i++) begin
      step();
      check("idle_dut0", outs(0), 19'd0);
      check("idle_dut1", outs(1), 19'd0);
      check_val("lfsr_nonzero", int'(u_dut0.u_lfsr.state_q != 16'd0), 1);
      check_val("lfsr_seq", int'(u_dut0.u_lfsr.state_q), int'(m_lfsr));
    end
  endtask

  // One round: expected waveform derived from D, TICK_DIV and the react cycle.
  task automatic run_round(input int k, input int react_at_in, input bit extra,
                           input int hold, input int tail, input bit exp_false);
    int  td, d, t, react_at, fs_edge, last;
    bit  is_false, e_rf, e_fs, e_busy;
    td = (k == 1) ? 4 : 1;
    d  = MIN_D + int'(m_lfsr[1:0]);
    t  = d * td;
    react_at = react_at_in;
    if (react_at == -2) react_at = t - 1;
    if (react_at == -3) react_at = t;
    is_false = (react_at >= 0) && (react_at < t);
    fs_edge  = react_at + 1;
    last = t;
    if (fs_edge > last) last = fs_edge;
    if (hold > last)    last = hold;
    last += tail;

    drive(k, 1'b1, 1'b0);
    step();
    for (int c = 0; c <= last; c++) begin
      e_rf   = !is_false && (c >= t);
      e_fs   = is_false && (c >= fs_edge);
      e_busy = is_false ? (c < fs_edge) : (c < t);
      check(k == 1 ? "round_td4" : "round_td1", outs(k), {e_rf, e_fs, e_busy, 16'(d)});
      if (c < last) begin
        drive(k, (c + 1 < hold) || (extra && c == 2), (c == react_at));
        step();
      end
    end
    check_val("final_false_start", int'(outs(k) >> 17) & 1, int'(exp_false));
    drive(k, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    int first_d, k, ra, d, t, td;
    bit ef;

    vecs[0]  = '{0, -1, 1'b0, 1,  4,     1'b0};
    vecs[1]  = '{1, -1, 1'b0, 1,  4,     1'b0};
    vecs[2]  = '{0,  3, 1'b0, 1,  4,     1'b1};
    vecs[3]  = '{1,  3, 1'b0, 1,  4,     1'b1};
    vecs[4]  = '{0, -1, 1'b1, 1,  4,     1'b0};
    vecs[5]  = '{1, -1, 1'b1, 1,  4,     1'b0};
    vecs[6]  = '{0, -1, 1'b0, 50, 4,     1'b0};
    vecs[7]  = '{0, -2, 1'b0, 1,  4,     1'b1};
    vecs[8]  = '{1, -2, 1'b0, 1,  4,     1'b1};
    vecs[9]  = '{0, -3, 1'b0, 1,  4,     1'b0};
    vecs[10] = '{1, -3, 1'b0, 1,  4,     1'b0};
    vecs[11] = '{0,  3, 1'b0, 1,  20000, 1'b1};

    reset = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);

    reset_and_idle(100);
    run_round(0, -1, 1'b0, 1, 4, 1'b0);
    first_d = int'(dly0);

    foreach (vecs[i])
      run_round(vecs[i].k, vecs[i].react_at, vecs[i].extra, vecs[i].hold, vecs[i].tail, vecs[i].exp_false);

    for (int n = 0; n < 30; n++) begin
      k  = int'($urandom_range(0, 1));
      td = (k == 1) ? 4 : 1;
      d  = MIN_D + int'(m_lfsr[1:0]);
      t  = d * td;
      ra = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, t + 3));
      ef = (ra >= 0) && (ra < t);
      run_round(k, ra, 1'b0, 1, int'($urandom_range(2, 6)), ef);
    end

    // Reset in the middle of a wait.
    drive(0, 1'b1, 1'b0);
    step();
    step();
    step();
    check_val("midwait_busy", int'(busy0), 1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0);
    step();
    check("reset_midwait", outs(0), 19'd0);
    reset = 1'b0;

    // Same offset from reset release must replay the first delay.
    reset_and_idle(100);
    run_round(0, -1, 1'b0, 1, 4, 1'b0);
    check_val("replay_delay", int'(dly0), first_d);

    check_val("in_fire", int'(rf0), 1);
    reset = 1'b1;
    step();
    check("reset_in_fire", outs(0), 19'd0);

    // Reset and start together: no round may begin.
    drive(0, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_start_same", outs(0), 19'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
